instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and fetch stage feeding the combinational instruction ROM.
//  - Drives the ROM address and captures the returned byte with its PC.
//  - Buffers fetched bytes in a small FIFO and presents them to the decoder
//    over a valid/ready handshake.
//  - Supports taken-branch redirect with flush, and signals end of program.
// PARAMETERS
//  PROG_LEN  5  number of valid ROM words; fetch stops when pc reaches it (1..256)
//  DEPTH     2  instruction queue entries (power of 2, >=2)
// PORTS
//  clk            in   1  rising-edge clock
//  clear          in   1  synchronous active-high reset
//  rom_addr       out  8  ROM address; always equals pc register
//  rom_data       in   8  ROM instruction; combinational from rom_addr, same cycle
//  branch_valid   in   1  redirect request from decode/execute
//  branch_target  in   8  new pc when branch_valid=1
//  out_valid      out  1  queue head holds an instruction
//  out_ready      in   1  decoder accepts head this cycle
//  out_instr      out  8  head instruction byte
//  out_pc         out  8  address the head was fetched from
//  retired_cnt    out  8  accepted handshakes since clear, saturates at 8'hFF
//  done           out  1  program exhausted and queue empty
// BEHAVIOUR
//  - Reset (clear=1 at posedge), all signals:
//    - pc=0, queue empty, state=RUN, retired_cnt=0.
//    - out_valid=0, done=0, rom_addr=0; out_instr/out_pc=0.
//  - pop  = out_valid & out_ready.
//  - push = state==RUN & pc<PROG_LEN & (count<DEPTH | pop) & ~branch_valid.
//  - On push:
//    - Enqueue {pc, rom_data}; pc<=pc+1 (8-bit).
//    - Fetch-to-out_valid latency is 1 cycle.
//  - Push and pop in the same cycle at count=DEPTH: both occur; count unchanged.
//  - Push and pop at count=0: push lands; out_valid=1 the next cycle.
//    There is no combinational bypass.
//  - States:
//    - RUN: fetching. Moves to DRAIN when a push makes pc==PROG_LEN.
//    - DRAIN: no fetch. Moves to DONE when count reaches 0 (after the last pop).
//    - DONE: done=1, out_valid=0. Remains here until a branch or clear.
//  - Branch (branch_valid=1), highest priority below clear:
//    - A pop in the same cycle still counts (retired_cnt increments).
//    - Queue is flushed to count=0 and pc<=branch_target; no push that cycle.
//    - Next state is RUN if branch_target<PROG_LEN, else DONE directly.
//    - Accepted from any state, including DONE.
//  - retired_cnt +1 per pop; holds at 8'hFF.
//  - FIFO read/write pointers wrap modulo DEPTH; count is 0..DEPTH.
//  - out_instr/out_pc are valid only when out_valid=1; they hold the last head
//    otherwise.
//  - clear mid-operation discards the queue and restarts at pc=0 on the next
//    cycle.
// TESTING
//  - ROM: 0:8'h44, 1:8'h49, 2:8'h18, 3:8'h89, 4:8'hC3; PROG_LEN=5, DEPTH=2.
//  - Stream: release clear, out_ready=1 always.
//    -> out_instr 44,49,18,89,C3 on consecutive cycles 1..5.
//    -> done=1 at cycle 7; retired_cnt=5.
//  - Backpressure: out_ready=0 for 4 cycles.
//    -> count stalls at 2 (44,49 held), rom_addr holds 2.
//    -> after release, order is 44,49,18,... with no loss or duplication.
//  - Branch: branch_valid=1, target=3 while head=49.
//    -> queue flushed, next out_pc=3/out_instr=89, then C3, then done=1.
//  - Branch from DONE: target=0.
//    -> done drops next cycle; stream restarts at 44.
//    -> target=9 instead: goes straight to DONE, out_valid stays 0.
//  - clear asserted with 2 entries queued: next cycle out_valid=0,
//    rom_addr=0, retired_cnt=0.
//  - Saturation: loop branch to 0 for 300 pops -> retired_cnt stays 8'hFF.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_unit: PC/fetch stage with instruction queue, branch redirect |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int PROG_LEN = 5,
  parameter int DEPTH    = 2
) (
  input  logic       clk,
  input  logic       clear,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_instr,
  output logic [7:0] out_pc,
  output logic [7:0] retired_cnt,
  output logic       done
);

  localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [8:0]  C_LEN = 9'(PROG_LEN);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_pc;
  logic [7:0]      r_mem_instr [DEPTH];
  logic [7:0]      r_mem_pc    [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_out_valid;
  logic [7:0]      r_out_instr;
  logic [7:0]      r_out_pc;
  logic [7:0]      r_retired;

  logic            w_pop;
  logic            w_push;
  logic            w_last;
  logic [PW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [7:0]      w_head_instr;
  logic [7:0]      w_head_pc;

  always_comb begin
    w_pop       = r_out_valid & out_ready;
    w_push      = (r_state == S_RUN) && ({1'b0, r_pc} < C_LEN) &&
                  ((r_count < CW'(DEPTH)) || w_pop) && !branch_valid;
    w_last      = (({1'b0, r_pc} + 9'd1) == C_LEN);
    w_rd_nxt    = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    // Head after this edge is the entry being written when the queue was
    // otherwise going empty; the mem slot isn't updated until the edge.
    if (w_push && (w_rd_nxt == r_wr_ptr)) begin
      w_head_instr = rom_data;
      w_head_pc    = r_pc;
    end else begin
      w_head_instr = r_mem_instr[w_rd_nxt];
      w_head_pc    = r_mem_pc[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= S_RUN;
      r_pc        <= 8'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= 8'd0;
      r_out_pc    <= 8'd0;
      r_retired   <= 8'd0;
    end else begin
      if (w_pop && (r_retired != 8'hFF)) begin
        r_retired <= r_retired + 8'd1;
      end
      if (branch_valid) begin
        r_pc        <= branch_target;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
        r_state     <= ({1'b0, branch_target} < C_LEN) ? S_RUN : S_DONE;
      end else begin
        if (w_push) begin
          r_mem_instr[r_wr_ptr] <= rom_data;
          r_mem_pc[r_wr_ptr]    <= r_pc;
          r_wr_ptr              <= r_wr_ptr + PW'(1);
          r_pc                  <= r_pc + 8'd1;
        end
        r_rd_ptr    <= w_rd_nxt;
        r_count     <= w_count_nxt;
        r_out_valid <= (w_count_nxt != '0);
        if (w_count_nxt != '0) begin
          r_out_instr <= w_head_instr;
          r_out_pc    <= w_head_pc;
        end
        case (r_state)
          S_RUN:   if (w_push && w_last) r_state <= S_DRAIN;
          S_DRAIN: if (r_count == '0)    r_state <= S_DONE;
          S_DONE:  r_state <= S_DONE;
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

  assign rom_addr    = r_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign retired_cnt = r_retired;
  assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic [7:0] retired_cnt;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (rom_addr)
      8'd0:    rom_data = 8'h44;
      8'd1:    rom_data = 8'h49;
      8'd2:    rom_data = 8'h18;
      8'd3:    rom_data = 8'h89;
      8'd4:    rom_data = 8'hC3;
      default: rom_data = 8'h00;
    endcase
  end

  instr_fetch_unit #(.PROG_LEN(5), .DEPTH(2)) dut (
    .clk(clk), .clear(clear), .rom_addr(rom_addr), .rom_data(rom_data),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .retired_cnt(retired_cnt), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    int pops;
    int cyc;
    exp_seq[0] = 8'h44; exp_seq[1] = 8'h49; exp_seq[2] = 8'h18;
    exp_seq[3] = 8'h89; exp_seq[4] = 8'hC3;

    clear = 1'b1; out_ready = 1'b1; branch_valid = 1'b0; branch_target = 8'd0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_retired", 32'(retired_cnt), 32'd0);
    check("rst_instr", 32'(out_instr), 32'd0);
    check("rst_pc", 32'(out_pc), 32'd0);

    // Free-running stream
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_instr", 32'(out_instr), 32'(exp_seq[i]));
      check("stream_pc", 32'(out_pc), i);
    end
    step();
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_done_early", 32'(done), 32'd0);
    check("stream_addr_end", 32'(rom_addr), 32'd5);
    step();
    check("stream_done", 32'(done), 32'd1);
    check("stream_retired", 32'(retired_cnt), 32'd5);

    // Backpressure
    do_clear();
    out_ready = 1'b0;
    repeat (4) step();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_instr", 32'(out_instr), 32'h44);
    check("bp_addr", 32'(rom_addr), 32'd2);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("bp_order", 32'(out_instr), 32'(exp_seq[i]));
    end

    // Branch while head is 49
    do_clear();
    step();
    check("br_head0", 32'(out_instr), 32'h44);
    step();
    check("br_head1", 32'(out_instr), 32'h49);
    branch_valid = 1'b1; branch_target = 8'd3;
    step();
    branch_valid = 1'b0;
    check("br_flush", 32'(out_valid), 32'd0);
    check("br_addr", 32'(rom_addr), 32'd3);
    check("br_retired", 32'(retired_cnt), 32'd2);
    step();
    check("br_pc3", 32'(out_pc), 32'd3);
    check("br_instr89", 32'(out_instr), 32'h89);
    step();
    check("br_instrC3", 32'(out_instr), 32'hC3);
    step(); step();
    check("br_done", 32'(done), 32'd1);
    check("br_retired_end", 32'(retired_cnt), 32'd4);

    // Branch out of DONE back to 0
    branch_valid = 1'b1; branch_target = 8'd0;
    step();
    branch_valid = 1'b0;
    check("bd_done_drop", 32'(done), 32'd0);
    step();
    check("bd_restart", 32'(out_instr), 32'h44);
    cyc = 0;
    while (!done && cyc < 20) begin step(); cyc++; end
    check("bd_redone", 32'(done), 32'd1);

    // Branch out of DONE past the program end
    branch_valid = 1'b1; branch_target = 8'd9;
    step();
    branch_valid = 1'b0;
    check("b9_done", 32'(done), 32'd1);
    check("b9_valid", 32'(out_valid), 32'd0);
    check("b9_addr", 32'(rom_addr), 32'd9);
    step();
    check("b9_valid_hold", 32'(out_valid), 32'd0);

    // clear with two queued entries
    out_ready = 1'b0;
    branch_valid = 1'b1; branch_target = 8'd0;
    step();
    branch_valid = 1'b0;
    repeat (3) step();
    check("cq_valid", 32'(out_valid), 32'd1);
    check("cq_addr", 32'(rom_addr), 32'd2);
    check("cq_retired_pre", 32'(retired_cnt), 32'd9);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("cq_valid_clr", 32'(out_valid), 32'd0);
    check("cq_addr_clr", 32'(rom_addr), 32'd0);
    check("cq_retired_clr", 32'(retired_cnt), 32'd0);

    // Saturation: rerun the program via branch until 300 pops
    out_ready = 1'b1;
    pops = 0;
    cyc  = 0;
    while (pops < 300 && cyc < 2000) begin
      if (out_valid) pops++;
      branch_valid  = done;
      branch_target = 8'd0;
      step();
      cyc++;
      if (pops == 255) check("sat_at255", 32'(retired_cnt), 32'hFF);
    end
    branch_valid = 1'b0;
    check("sat_budget", 32'(pops >= 300), 32'd1);
    check("sat_retired", 32'(retired_cnt), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
